disp_ctrl: RTL and testbench

Multi-channel seven-segment display controller that generalises the fixed two-value combinational bcd/ssd display path. It snapshots CHANNELS binary values on an update strobe and converts each one sequentially to digits. Decimal mode uses a shift-and-add-3 (double-dabble) FSM, one bit per cycle; hex mode uses direct nibbles. Outputs are registered segment codes with leading-zero blanking and per-channel overflow indication. It sits between the CPU-status signals (pc, sp, out) and the board hex outputs, clocked by the system clock.

---
 rtl/disp_pkg.sv | 47 ++++
 rtl/disp_ctrl_if.sv | 24 ++
 rtl/disp_ctrl_bin2bcd.sv | 56 +++++
 rtl/disp_ctrl.sv | 154 +++++++++++++++
 tb/tb_disp_ctrl.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// Shared types and helpers for the multi-channel seven-segment display controller.
package disp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_STORE,
    ST_DONE
  } state_t;

  // Active-low segment codes, bit 0 = segment a, bit 6 = segment g
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  function automatic logic [6:0] seg_encode(input logic [3:0] val);
    logic [6:0] seg;
    case (val)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // 10^n, used to decide whether a decimal value fits in the digit count
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/disp_ctrl_if.sv
// Bus between the CPU-status side and the display controller.
interface disp_ctrl_if #(
  parameter int CHANNELS = 2,
  parameter int IN_WIDTH = 6,
  parameter int DIGITS   = 2
);
  logic [CHANNELS*IN_WIDTH-1:0] i_in;
  logic                         i_update;
  logic                         i_mode;
  logic                         i_blank_lz;
  logic                         o_busy;
  logic [CHANNELS-1:0]          o_overflow;
  logic [CHANNELS*DIGITS*7-1:0] o_hex;

  modport master (
    output i_in, i_update, i_mode, i_blank_lz,
    input  o_busy, o_overflow, o_hex
  );

  modport slave (
    input  i_in, i_update, i_mode, i_blank_lz,
    output o_busy, o_overflow, o_hex
  );
endinterface

// File: rtl/disp_ctrl_bin2bcd.sv
// Sequential shift-and-add-3 binary to BCD converter, one input bit per cycle.
// Carries out of the top nibble are dropped, so the result is value mod 10^DIGITS.
module bin2bcd_seq #(
  parameter int IN_WIDTH = 6,
  parameter int DIGITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [IN_WIDTH-1:0]   i_value,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);
  localparam int CNT_W = $clog2(IN_WIDTH + 1);

  logic [IN_WIDTH-1:0]          r_shift;
  logic [4*DIGITS-1:0]          r_bcd;
  logic [CNT_W-1:0]             r_cnt;
  logic                         r_active;
  logic [4*DIGITS-1:0]          w_adj;
  logic [4*DIGITS+IN_WIDTH-1:0] w_cat;

  // Add 3 to every nibble that is 5 or more, then shift {bcd, shift} left by one
  always_comb begin
    w_adj = r_bcd;
    for (int n = 0; n < DIGITS; n++) begin
      if (r_bcd[4*n +: 4] >= 4'd5) w_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
    end
    w_cat = {w_adj[4*DIGITS-2:0], r_shift, 1'b0};
  end

  // Load on start, then shift one bit per cycle until the counter runs out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift  <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_shift  <= i_value;
      r_bcd    <= '0;
      r_cnt    <= CNT_W'(IN_WIDTH);
      r_active <= 1'b1;
    end else if (r_active) begin
      r_bcd    <= w_cat[4*DIGITS+IN_WIDTH-1:IN_WIDTH];
      r_shift  <= w_cat[IN_WIDTH-1:0];
      r_cnt    <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) r_active <= 1'b0;
    end
  end

  // Done marks the cycle whose edge performs the final shift
  assign o_done = r_active && (r_cnt == CNT_W'(1));
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/disp_ctrl.sv
// Multi-channel seven-segment display controller: snapshots all channels on update,
// converts them one after another and publishes every digit in a single edge.
module disp_ctrl #(
  parameter int CHANNELS = 2,
  parameter int IN_WIDTH = 6,
  parameter int DIGITS   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  disp_ctrl_if.slave bus
);
  import disp_pkg::*;

  localparam int          HEX_W = CHANNELS * DIGITS * 7;
  localparam int          SEG_W = DIGITS * 7;
  localparam int          CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int          EXT_W = IN_WIDTH + 4 * DIGITS;
  localparam logic [63:0] POW10 = pow10(DIGITS);

  state_t                       r_state, w_next;
  logic [CH_W-1:0]              r_ch;
  logic [CHANNELS*IN_WIDTH-1:0] r_snap;
  logic                         r_mode, r_blank, r_busy;
  logic [HEX_W-1:0]             r_shadowHex, r_hex;
  logic [CHANNELS-1:0]          r_shadowOvf, r_ovf;
  logic                         w_capture, w_start, w_store, w_finish, w_lastCh;
  logic                         w_done, w_ovf, w_lead;
  logic [IN_WIDTH-1:0]          w_value;
  logic [EXT_W-1:0]             w_ext;
  logic [4*DIGITS-1:0]          w_bcd;
  logic [3:0]                   w_dig;
  logic [SEG_W-1:0]             w_segs;

  assign w_value  = r_snap[r_ch*IN_WIDTH +: IN_WIDTH];
  assign w_ext    = {{(4*DIGITS){1'b0}}, w_value};
  assign w_lastCh = (r_ch == CH_W'(CHANNELS - 1));

  bin2bcd_seq #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) u_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_value (w_value),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and control strobes for capture, conversion, store and publish
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_start   = 1'b0;
    w_store   = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_update) begin
          w_capture = 1'b1;
          w_next    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (r_mode) begin
          w_next = ST_STORE;
        end else begin
          w_start = 1'b1;
          w_next  = ST_SHIFT;
        end
      end
      ST_SHIFT: if (w_done) w_next = ST_STORE;
      ST_STORE: begin
        w_store = 1'b1;
        w_next  = w_lastCh ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        w_finish = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Overflow test and segment codes for the current channel, with leading-zero blanking
  always_comb begin
    w_ovf  = r_mode ? (|w_ext[EXT_W-1:4*DIGITS]) : (64'(w_value) >= POW10);
    w_lead = 1'b1;
    w_dig  = '0;
    w_segs = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      w_dig = r_mode ? w_ext[4*d +: 4] : w_bcd[4*d +: 4];
      if (w_ovf)
        w_segs[7*d +: 7] = SEG_DASH;
      else if (r_blank && w_lead && (d != 0) && (w_dig == 4'd0))
        w_segs[7*d +: 7] = SEG_BLANK;
      else
        w_segs[7*d +: 7] = seg_encode(w_dig);
      if (w_dig != 4'd0) w_lead = 1'b0;
    end
  end

  // Snapshot of inputs and channel sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap  <= '0;
      r_mode  <= 1'b0;
      r_blank <= 1'b0;
      r_ch    <= '0;
    end else if (w_capture) begin
      r_snap  <= bus.i_in;
      r_mode  <= bus.i_mode;
      r_blank <= bus.i_blank_lz;
      r_ch    <= '0;
    end else if (w_store && !w_lastCh) begin
      r_ch    <= r_ch + CH_W'(1);
    end
  end

  // Shadow registers collect each channel's result until the whole set is ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadowHex <= '1;
      r_shadowOvf <= '0;
    end else if (w_store) begin
      r_shadowHex[r_ch*SEG_W +: SEG_W] <= w_segs;
      r_shadowOvf[r_ch]                <= w_ovf;
    end
  end

  // Visible outputs change only when the full conversion is published
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex  <= '1;
      r_ovf  <= '0;
      r_busy <= 1'b0;
    end else begin
      if (w_capture) r_busy <= 1'b1;
      if (w_finish) begin
        r_hex  <= r_shadowHex;
        r_ovf  <= r_shadowOvf;
        r_busy <= 1'b0;
      end
    end
  end

  assign bus.o_hex      = r_hex;
  assign bus.o_overflow = r_ovf;
  assign bus.o_busy     = r_busy;

endmodule

// File: tb/tb_disp_ctrl.sv
// Bench for disp_ctrl: a two-digit and a one-digit build share the same stimulus
// and are compared against an arithmetic model of the display rules.
module tb_disp_ctrl;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  disp_ctrl_if #(.CHANNELS(2), .IN_WIDTH(6), .DIGITS(2)) busA ();
  disp_ctrl_if #(.CHANNELS(2), .IN_WIDTH(6), .DIGITS(1)) busB ();

  disp_ctrl #(.CHANNELS(2), .IN_WIDTH(6), .DIGITS(2)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA.slave)
  );

  disp_ctrl #(.CHANNELS(2), .IN_WIDTH(6), .DIGITS(1)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB.slave)
  );

  // Expected display: digits by division in the chosen base, dashes on overflow,
  // digits above the most significant nonzero one blanked when requested
  function automatic void refModel(input logic [11:0] vals, input bit m, input bit bl,
                                   input int digs, output logic [27:0] h, output logic [1:0] ov);
    int base, lim, v, msd, p, dig;
    h = '0;
    ov = '0;
    base = m ? 16 : 10;
    for (int c = 0; c < 2; c++) begin
      v = int'(vals[c*6 +: 6]);
      lim = 1;
      for (int i = 0; i < digs; i++) lim = lim * base;
      ov[c] = (v >= lim);
      msd = 0;
      p = 1;
      for (int d = 0; d < digs; d++) begin
        dig = (v / p) % base;
        if (dig != 0) msd = d;
        p = p * base;
      end
      p = 1;
      for (int d = 0; d < digs; d++) begin
        dig = (v / p) % base;
        if (ov[c])
          h[(c*digs+d)*7 +: 7] = 7'h3F;
        else if (bl && d > msd)
          h[(c*digs+d)*7 +: 7] = 7'h7F;
        else
          h[(c*digs+d)*7 +: 7] = SEG_TABLE[dig];
        p = p * base;
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic driveInputs(input logic [11:0] vals, input bit m, input bit bl, input bit upd);
    busA.i_in = vals; busA.i_mode = m; busA.i_blank_lz = bl; busA.i_update = upd;
    busB.i_in = vals; busB.i_mode = m; busB.i_blank_lz = bl; busB.i_update = upd;
  endtask

  // One full conversion; optionally disturbs the inputs and pulses update mid-way
  task automatic applyStimulus(input logic [11:0] vals, input bit m, input bit bl, input bit disturb);
    logic [27:0] expA, expB, prevHex;
    logic [1:0]  ovA, ovB;
    int          busyCycles;
    bit          stable;
    refModel(vals, m, bl, 2, expA, ovA);
    refModel(vals, m, bl, 1, expB, ovB);
    @(negedge clk);
    driveInputs(vals, m, bl, 1'b1);
    prevHex = busA.o_hex;
    stable = 1'b1;
    @(negedge clk);
    driveInputs(vals, m, bl, 1'b0);
    busyCycles = 0;
    while (busA.o_busy === 1'b1 && busyCycles < 100) begin
      busyCycles++;
      if (busA.o_hex !== prevHex) stable = 1'b0;
      if (disturb && busyCycles == 3) driveInputs(12'($urandom), ~m, ~bl, 1'b1);
      else if (disturb && busyCycles == 4) driveInputs(12'($urandom), ~m, ~bl, 1'b0);
      @(negedge clk);
    end
    checkOutput("latency", 64'(busyCycles), m ? 64'd5 : 64'd17);
    checkOutput("stableWhileBusy", 64'(stable), 64'd1);
    checkOutput("hexD2", 64'(busA.o_hex), 64'(expA));
    checkOutput("ovfD2", 64'(busA.o_overflow), 64'(ovA));
    checkOutput("hexD1", 64'(busB.o_hex), 64'(expB[13:0]));
    checkOutput("ovfD1", 64'(busB.o_overflow), 64'(ovB));
    checkOutput("busyD1", 64'(busB.o_busy), 64'd0);
  endtask

  // Directed steps followed by randomized conversions
  initial begin
    bit stable;
    logic [11:0] vals;
    driveInputs(12'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rstHexD2", 64'(busA.o_hex), 64'h0FFF_FFFF);
    checkOutput("rstHexD1", 64'(busB.o_hex), 64'h3FFF);
    checkOutput("rstBusy", 64'(busA.o_busy), 64'd0);
    checkOutput("rstOvf", 64'(busA.o_overflow), 64'd0);
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busA.o_hex !== 28'h0FFF_FFFF || busA.o_busy !== 1'b0) stable = 1'b0;
    end
    checkOutput("idleStable", 64'(stable), 64'd1);

    applyStimulus({6'd7, 6'd42}, 1'b0, 1'b0, 1'b0);
    checkOutput("plan42_7", 64'(busA.o_hex), 64'({7'h40, 7'h78, 7'h19, 7'h24}));
    applyStimulus({6'd7, 6'd0}, 1'b0, 1'b1, 1'b0);
    checkOutput("planBlank", 64'(busA.o_hex), 64'({7'h7F, 7'h78, 7'h7F, 7'h40}));
    applyStimulus({6'd10, 6'd63}, 1'b1, 1'b0, 1'b0);
    checkOutput("planHex", 64'(busA.o_hex), 64'({7'h40, 7'h08, 7'h30, 7'h0E}));
    applyStimulus({6'd9, 6'd12}, 1'b0, 1'b0, 1'b0);
    checkOutput("planD1Hex", 64'(busB.o_hex), 64'({7'h10, 7'h3F}));
    checkOutput("planD1Ovf", 64'(busB.o_overflow), 64'd1);
    applyStimulus({6'd35, 6'd18}, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of a conversion
    @(negedge clk);
    driveInputs({6'd55, 6'd61}, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    driveInputs({6'd55, 6'd61}, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstHexD2", 64'(busA.o_hex), 64'h0FFF_FFFF);
    checkOutput("midRstHexD1", 64'(busB.o_hex), 64'h3FFF);
    checkOutput("midRstBusy", 64'(busA.o_busy), 64'd0);
    checkOutput("midRstOvf", 64'(busA.o_overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus({6'd55, 6'd61}, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      vals = 12'($urandom);
      applyStimulus(vals, 1'($urandom), 1'($urandom), (i % 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
